// File: rtl/issue_scheduler_pkg.sv
// rtl/issue_scheduler_pkg.sv - shared unit ids, default latencies and helpers for the issue scheduler
package issue_scheduler_pkg;

  typedef enum logic [1:0] {
    EU_INT  = 2'd0,
    EU_MEM  = 2'd1,
    EU_MULT = 2'd2,
    EU_DIV  = 2'd3
  } exec_unit_e;

  localparam int INT_LAT_C  = 1;
  localparam int MEM_LAT_C  = 2;
  localparam int MULT_LAT_C = 4;
  localparam int DIV_LAT_C  = 8;

  function automatic int lat_max(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/issue_scheduler_if.sv
// rtl/issue_scheduler_if.sv - station ready/done handshake and CDB owner bus of the issue scheduler
// Optional stall counters appear when ISSUE_STALL_CNT_EN is defined.
interface issue_scheduler_if;
  import issue_scheduler_pkg::*;

  logic       flush;
  logic       int_rdy;
  logic       mem_rdy;
  logic       mult_rdy;
  logic       div_rdy;
  logic       issue_done_int;
  logic       issue_done_mem;
  logic       issue_done_mult;
  logic       issue_done_div;
  logic       cdb_slot_valid;
  exec_unit_e cdb_owner;
  logic       div_busy;
`ifdef ISSUE_STALL_CNT_EN
  logic [15:0] stall_cnt_int;
  logic [15:0] stall_cnt_mem;
  logic [15:0] stall_cnt_mult;
  logic [15:0] stall_cnt_div;
`endif

  modport master (
    output flush, int_rdy, mem_rdy, mult_rdy, div_rdy,
    input  issue_done_int, issue_done_mem, issue_done_mult, issue_done_div,
    input  cdb_slot_valid, cdb_owner, div_busy
`ifdef ISSUE_STALL_CNT_EN
    , input stall_cnt_int, stall_cnt_mem, stall_cnt_mult, stall_cnt_div
`endif
  );

  modport slave (
    input  flush, int_rdy, mem_rdy, mult_rdy, div_rdy,
    output issue_done_int, issue_done_mem, issue_done_mult, issue_done_div,
    output cdb_slot_valid, cdb_owner, div_busy
`ifdef ISSUE_STALL_CNT_EN
    , output stall_cnt_int, stall_cnt_mem, stall_cnt_mult, stall_cnt_div
`endif
  );

endinterface

// File: rtl/issue_scheduler_rr_arbiter4.sv
// rtl/issue_scheduler_rr_arbiter4.sv - combinational 4-way round-robin picker, search starts at ptr
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// rtl/issue_scheduler.sv - single-issue round-robin scheduler with CDB slot reservation and divider tracking
// Define ISSUE_STALL_CNT_EN to add per-station saturating stall counters.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int INT_LAT  = INT_LAT_C,
  parameter int MEM_LAT  = MEM_LAT_C,
  parameter int MULT_LAT = MULT_LAT_C,
  parameter int DIV_LAT  = DIV_LAT_C
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  issue_scheduler_if.slave   bus
);

  localparam int MAX_LAT = lat_max(INT_LAT, MEM_LAT, MULT_LAT, DIV_LAT);
  localparam int DCW     = $clog2(DIV_LAT);

  logic [MAX_LAT:0]       resv_q,  resv_d;
  logic [MAX_LAT:0][1:0]  owner_q, owner_d;
  logic [1:0]             rr_q,    rr_d;
  logic [DCW-1:0]         div_cnt_q, div_cnt_d;

  logic [3:0] rdy;
  logic [3:0] elig;
  logic [3:0] gnt;
  logic [1:0] gnt_id;

  assign rdy = {bus.div_rdy, bus.mult_rdy, bus.mem_rdy, bus.int_rdy};

  // Reset gates grants so issue_done stays low while i_rst_n is held, even with stations ready.
  always_comb begin
    elig[0] = rdy[0] & ~resv_q[INT_LAT];
    elig[1] = rdy[1] & ~resv_q[MEM_LAT];
    elig[2] = rdy[2] & ~resv_q[MULT_LAT];
    elig[3] = rdy[3] & ~resv_q[DIV_LAT] & (div_cnt_q == '0);
    elig    = elig & {4{~bus.flush & i_rst_n}};
  end

  rr_arbiter4 u_arb (
    .req (elig),
    .ptr (rr_q),
    .gnt (gnt)
  );

  always_comb begin
    gnt_id = 2'd0;
    if (gnt[1]) gnt_id = 2'd1;
    if (gnt[2]) gnt_id = 2'd2;
    if (gnt[3]) gnt_id = 2'd3;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      resv_q    <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      div_cnt_q <= '0;
    end else begin
      resv_q    <= resv_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  // The slot check guarantees resv[L-1] is free after the shift, so a grant never overwrites a reservation.
  always_comb begin
    resv_d    = {1'b0, resv_q[MAX_LAT:1]};
    owner_d   = {2'b00, owner_q[MAX_LAT:1]};
    rr_d      = rr_q;
    div_cnt_d = (div_cnt_q != '0) ? div_cnt_q - DCW'(1) : div_cnt_q;
    if (gnt[0]) begin
      resv_d[INT_LAT-1]  = 1'b1;
      owner_d[INT_LAT-1] = EU_INT;
    end
    if (gnt[1]) begin
      resv_d[MEM_LAT-1]  = 1'b1;
      owner_d[MEM_LAT-1] = EU_MEM;
    end
    if (gnt[2]) begin
      resv_d[MULT_LAT-1]  = 1'b1;
      owner_d[MULT_LAT-1] = EU_MULT;
    end
    if (gnt[3]) begin
      resv_d[DIV_LAT-1]  = 1'b1;
      owner_d[DIV_LAT-1] = EU_DIV;
      div_cnt_d          = DCW'(DIV_LAT - 1);
    end
    if (|gnt) rr_d = gnt_id + 2'd1;
    if (bus.flush) begin
      resv_d    = '0;
      owner_d   = '0;
      div_cnt_d = '0;
    end
  end

  always_comb begin
    bus.issue_done_int  = gnt[0];
    bus.issue_done_mem  = gnt[1];
    bus.issue_done_mult = gnt[2];
    bus.issue_done_div  = gnt[3];
    bus.cdb_slot_valid  = resv_q[0];
    bus.cdb_owner       = exec_unit_e'(resv_q[0] ? owner_q[0] : 2'd0);
    bus.div_busy        = (div_cnt_q != '0);
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [3:0][15:0] stall_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else begin
      for (int u = 0; u < 4; u++) begin
        if (rdy[u] && !gnt[u] && stall_q[u] != 16'hFFFF) stall_q[u] <= stall_q[u] + 16'd1;
      end
    end
  end

  assign bus.stall_cnt_int  = stall_q[0];
  assign bus.stall_cnt_mem  = stall_q[1];
  assign bus.stall_cnt_mult = stall_q[2];
  assign bus.stall_cnt_div  = stall_q[3];
`endif

endmodule

// File: tb/tb_issue_scheduler.sv
// tb/tb_issue_scheduler.sv - scoreboard bench for issue_scheduler against an absolute-time slot-booking model
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  typedef struct packed {
    logic [3:0]       gnt;
    logic             v;
    logic [1:0]       own;
    logic             busy;
    logic [3:0][15:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  issue_scheduler_if bus ();

  issue_scheduler dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];

  int lat[4] = '{INT_LAT_C, MEM_LAT_C, MULT_LAT_C, DIV_LAT_C};
  int cyc = 0;
  int slot_own[int];
  int div_ok = 0;
  int rr = 0;
  logic [3:0][15:0] stall_m = '0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // One cycle of stimulus; the model books CDB cycles in absolute time and knows when the divider frees up.
  task automatic step(input logic [3:0] rdy, input logic fl, input logic rn);
    exp_t e;
    int u;
    int keys[$];
    @(posedge clk);
    #1;
    rst_n        = rn;
    bus.flush    = fl;
    bus.int_rdy  = rdy[0];
    bus.mem_rdy  = rdy[1];
    bus.mult_rdy = rdy[2];
    bus.div_rdy  = rdy[3];
    e = '0;
    if (!rn) begin
      slot_own.delete();
      div_ok  = cyc;
      rr      = 0;
      stall_m = '0;
    end else begin
      e.v     = slot_own.exists(cyc);
      e.own   = e.v ? 2'(slot_own[cyc]) : 2'd0;
      e.busy  = (cyc < div_ok);
      e.stall = stall_m;
      if (!fl) begin
        for (int i = 0; i < 4; i++) begin
          u = (rr + i) % 4;
          if (e.gnt == 4'd0 && rdy[u] && !slot_own.exists(cyc + lat[u]) && (u != 3 || cyc >= div_ok)) begin
            e.gnt[u] = 1'b1;
            slot_own[cyc + lat[u]] = u;
            rr = (u + 1) % 4;
            if (u == 3) div_ok = cyc + DIV_LAT_C;
          end
        end
      end
      for (int k = 0; k < 4; k++)
        if (rdy[k] && !e.gnt[k] && stall_m[k] != 16'hFFFF) stall_m[k] = stall_m[k] + 16'd1;
      if (fl) begin
        foreach (slot_own[key]) if (key > cyc) keys.push_back(key);
        foreach (keys[j]) slot_own.delete(keys[j]);
        if (div_ok > cyc + 1) div_ok = cyc + 1;
      end
      if (slot_own.exists(cyc)) slot_own.delete(cyc);
    end
    sb_q.push_back(e);
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("issue_done", {bus.issue_done_div, bus.issue_done_mult, bus.issue_done_mem, bus.issue_done_int}, e.gnt);
      chk("cdb_slot_valid", bus.cdb_slot_valid, e.v);
      chk("cdb_owner", bus.cdb_owner, e.own);
      chk("div_busy", bus.div_busy, e.busy);
`ifdef ISSUE_STALL_CNT_EN
      chk("stall_cnt_int", bus.stall_cnt_int, e.stall[0]);
      chk("stall_cnt_mem", bus.stall_cnt_mem, e.stall[1]);
      chk("stall_cnt_mult", bus.stall_cnt_mult, e.stall[2]);
      chk("stall_cnt_div", bus.stall_cnt_div, e.stall[3]);
`endif
    end
  end

  initial begin
    bus.flush    = 1'b0;
    bus.int_rdy  = 1'b0;
    bus.mem_rdy  = 1'b0;
    bus.mult_rdy = 1'b0;
    bus.div_rdy  = 1'b0;

    repeat (3) step(4'hF, 1'b0, 1'b0);
    repeat (14) step(4'hF, 1'b0, 1'b1);

    step(4'h0, 1'b0, 1'b0);
    repeat (5) step(4'h1, 1'b0, 1'b1);

    step(4'h0, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);
    step(4'h1, 1'b0, 1'b1);
    step(4'h1, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);
    step(4'h0, 1'b0, 1'b1);

    step(4'h0, 1'b0, 1'b0);
    step(4'h4, 1'b0, 1'b1);
    step(4'h8, 1'b0, 1'b1);
    step(4'hF, 1'b1, 1'b1);
    repeat (10) step(4'hF, 1'b0, 1'b1);

    step(4'h0, 1'b0, 1'b0);
    repeat (3) step(4'hF, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_issue_done", {bus.issue_done_div, bus.issue_done_mult, bus.issue_done_mem, bus.issue_done_int}, 0);
    chk("async_cdb_slot_valid", bus.cdb_slot_valid, 0);
    chk("async_cdb_owner", bus.cdb_owner, 0);
    chk("async_div_busy", bus.div_busy, 0);
    step(4'hF, 1'b0, 1'b0);
    repeat (12) step(4'h0, 1'b0, 1'b1);

    for (int n = 0; n < 2000; n++)
      step(4'($urandom), ($urandom_range(15) == 0), ($urandom_range(199) != 0));

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
